engine_round_scheduler: RTL and testbench
=========================================

# engine_round_scheduler

Control FSM that sequences the AES engine datapath. It accepts a cipher key from the host and drives the round-key generator's start handshake, then waits for the generator's `transformer_start` completion. For each accepted data block it steps the round transformer through rounds 0..ROUNDS, selecting one round key per cycle, and reports completion. It sits between the host interface and the `engine_key_generator` / round transformer pair.

## Interface
Parameters:
- `ROUNDS`, 10: last round index; `round_sel` runs 0..ROUNDS. Legal range 1..15.
- `KEYGEN_TIMEOUT`, 64: maximum cycles spent in KEYGEN before an error is flagged. Legal range ≥2.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_`, input, 1: asynchronous, active-high reset.
- `key_valid`, input, 1: host presents a new key.
- `key_in`, input, 128: host key.
- `key_ready`, output, 1: scheduler can accept a key.
- `blk_valid`, input, 1: host presents a data block. The data path itself is outside this block.
- `blk_ready`, output, 1: scheduler can accept a block.
- `key_start`, output, 1: start request to the key generator.
- `key_q`, output, 128: registered key driven to the generator's `key_in`.
- `transformer_start`, input, 1: key generator reports that the round keys are valid. Level signal.
- `round_sel`, output, 4: round-key mux select and round index for the transformer.
- `round_en`, output, 1: transformer performs the round `round_sel` this cycle.
- `round_last`, output, 1: high when `round_en` is high and `round_sel`==ROUNDS.
- `blk_done`, output, 1: one-cycle pulse, block finished.
- `busy`, output, 1: high in KEYGEN, ROUND and DONE.
- `key_err`, output, 1: sticky key-generation timeout flag.

## Operation
States: IDLE, KEYGEN, READY, ROUND, DONE, ERR. All outputs are registered except `key_ready`, `blk_ready` and `round_last`, which are decoded from the state and inputs.

- **IDLE:** `key_ready`=1, `blk_ready`=0.
  - On `key_valid`: latch `key_in` into `key_q`, clear the timeout counter, go to KEYGEN.
- **KEYGEN:** `key_start`=1, held high for the whole state. The timeout counter increments every cycle.
  - `transformer_start`=1 → READY. Checked first, so it wins over a timeout in the same cycle.
  - Counter reaches KEYGEN_TIMEOUT−1 with `transformer_start`=0 → ERR, `key_err`←1.
- **READY:** `key_ready`=1, `blk_ready`=!`key_valid`, so a key wins a simultaneous request.
  - `key_valid` → relatch `key_q`, go to KEYGEN.
  - Otherwise `blk_valid` → ROUND with `round_sel`=0.
- **ROUND:** `round_en`=1. `round_sel` increments every cycle.
  - At `round_sel`==ROUNDS → DONE and `round_sel`←0.
  - `key_valid` is ignored and `key_ready`=0.
- **DONE:** `blk_done`=1 for exactly one cycle, then → READY. `key_ready`=0 and `blk_ready`=0.
- **ERR:** `key_ready`=1. On `key_valid`: latch the key, clear `key_err`, go to KEYGEN. `blk_ready`=0.
- `key_start` deasserts in the cycle after `transformer_start` is sampled high. It is never high outside KEYGEN.
- A handshake completes when valid and ready are both high at a rising edge. Valid may drop at any time with no effect until a handshake completes.

## Timing
- Reset values: state=IDLE, `key_q`=0, `round_sel`=0, timeout counter=0.
- Reset outputs: `key_start`=0, `round_en`=0, `blk_done`=0, `busy`=0, `key_err`=0, `key_ready`=1, `blk_ready`=0.
- Key load: key handshake at edge t → `key_start`=1 from t+1. `transformer_start` sampled high at edge u → READY and `key_start`=0 from u+1.
- Block latency: block handshake at edge t → `round_en`=1 during cycles t+1..t+ROUNDS+1, with `round_sel`=0..ROUNDS. `blk_done`=1 in cycle t+ROUNDS+2. `blk_ready`=1 again in cycle t+ROUNDS+3.
- Sustained throughput is one block per ROUNDS+3 cycles.
- The timeout counter is ⌈log2(KEYGEN_TIMEOUT)⌉+1 bits wide and saturates. It never wraps.
- `round_sel` never exceeds ROUNDS.
- Asserting `rst_` mid-ROUND or mid-KEYGEN aborts immediately: no `blk_done`, `key_start` drops asynchronously, the key is discarded, and a new key load is required.

## Test plan
1. Reset, then key 2475A2B33475568831E2120013AA5487 → `key_q` equals the key one cycle after the handshake, `key_start` stays high until `transformer_start` (generator tied in), then READY with `key_ready`=`blk_ready`=1.
2. In READY, a one-cycle `blk_valid` → exactly 11 `round_en` cycles with `round_sel` 0,1..10, `round_last` only at 10, a single `blk_done` 12 cycles after the handshake.
3. `transformer_start` held at 0 → `key_err`=1 exactly 64 cycles after entering KEYGEN, `blk_ready` stays 0. A new key then clears `key_err` and re-enters KEYGEN.
4. `key_valid` and `blk_valid` both high in READY → the key is taken and the block is not (`blk_ready`=0 that cycle). The block is accepted after the rekey completes.
5. Assert `rst_` at `round_sel`=5 → all outputs take their reset values immediately, no `blk_done`, `blk_ready` stays 0 until a new key load.
6. Back-to-back blocks with `blk_valid` held high → successive `blk_done` pulses exactly 13 cycles apart.

Source files
------------

// File: rtl/engine_round_scheduler.sv
// engine_round_scheduler: control FSM for the AES engine datapath.
// Loads a host key, runs the round-key generator start handshake, then steps
// the round transformer through rounds 0..ROUNDS for every accepted block.
//
// Handshakes: a transfer on key_valid/key_ready or blk_valid/blk_ready happens
// only when valid and ready are both high at a rising clk edge. Valid may drop
// at any time without effect until such an edge. When a key and a block are
// offered together in READY the key wins: blk_ready is forced low.
module engine_round_scheduler #(
  parameter int ROUNDS         = 10,
  parameter int KEYGEN_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic         blk_valid,
  output logic         blk_ready,
  output logic         key_start,
  output logic [127:0] key_q,
  input  logic         transformer_start,
  output logic [3:0]   round_sel,
  output logic         round_en,
  output logic         round_last,
  output logic         blk_done,
  output logic         busy,
  output logic         key_err,
  output logic [2:0]   state_dbg
);

  localparam int CW = $clog2(KEYGEN_TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(KEYGEN_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [3:0]    LAST_RND = 4'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYGEN = 3'd1,
    S_READY  = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [3:0]     sel_n;
  logic           err_n;
  logic           key_load;

  assign state_dbg  = state;
  assign round_last = round_en && (round_sel == LAST_RND);

  // Next-state, counter and decoded handshake-ready logic.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sel_n     = round_sel;
    err_n     = key_err;
    key_load  = 1'b0;
    key_ready = 1'b0;
    blk_ready = 1'b0;
    case (state)
      S_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          key_load = 1'b1;
          cnt_n    = '0;
          state_n  = S_KEYGEN;
        end
      end
      S_KEYGEN: begin
        // Saturating count of cycles spent waiting for the generator.
        if (cnt != CNT_MAX) cnt_n = cnt + CW'(1);
        // Generator completion is checked first so it beats a same-cycle timeout.
        if (transformer_start) begin
          state_n = S_READY;
        end else if (cnt == TO_LAST) begin
          state_n = S_ERR;
          err_n   = 1'b1;
        end
      end
      S_READY: begin
        key_ready = 1'b1;
        blk_ready = !key_valid;
        if (key_valid) begin
          key_load = 1'b1;
          cnt_n    = '0;
          state_n  = S_KEYGEN;
        end else if (blk_valid) begin
          sel_n   = '0;
          state_n = S_ROUND;
        end
      end
      S_ROUND: begin
        if (round_sel == LAST_RND) begin
          sel_n   = '0;
          state_n = S_DONE;
        end else begin
          sel_n = round_sel + 4'd1;
        end
      end
      S_DONE: begin
        state_n = S_READY;
      end
      S_ERR: begin
        key_ready = 1'b1;
        if (key_valid) begin
          key_load = 1'b1;
          cnt_n    = '0;
          err_n    = 1'b0;
          state_n  = S_KEYGEN;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state     <= S_IDLE;
      cnt       <= '0;
      round_sel <= '0;
      key_q     <= '0;
      key_err   <= 1'b0;
      key_start <= 1'b0;
      round_en  <= 1'b0;
      blk_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      round_sel <= sel_n;
      key_err   <= err_n;
      if (key_load) key_q <= key_in;
      key_start <= (state_n == S_KEYGEN);
      round_en  <= (state_n == S_ROUND);
      blk_done  <= (state_n == S_DONE);
      busy      <= (state_n == S_KEYGEN) || (state_n == S_ROUND) || (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_engine_round_scheduler.sv
// Directed bench for engine_round_scheduler with an expected-event scoreboard.
module tb_engine_round_scheduler;

  localparam int ROUNDS = 10;
  localparam int TO     = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_KEYGEN = 3'd1;
  localparam logic [2:0] ST_READY = 3'd2;
  localparam logic [2:0] ST_ERR   = 3'd5;

  logic         clk;
  logic         rst_;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         blk_valid;
  logic         blk_ready;
  logic         key_start;
  logic [127:0] key_q;
  logic         transformer_start;
  logic [3:0]   round_sel;
  logic         round_en;
  logic         round_last;
  logic         blk_done;
  logic         busy;
  logic         key_err;
  logic [2:0]   state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];
  logic       err_prev = 1'b0;

  engine_round_scheduler #(.ROUNDS(ROUNDS), .KEYGEN_TIMEOUT(TO)) dut (
    .clk(clk), .rst_(rst_), .key_valid(key_valid), .key_in(key_in),
    .key_ready(key_ready), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .key_start(key_start), .key_q(key_q), .transformer_start(transformer_start),
    .round_sel(round_sel), .round_en(round_en), .round_last(round_last),
    .blk_done(blk_done), .busy(busy), .key_err(key_err), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // scoreboard monitor: every round, block completion and error rise pops one entry
  task automatic mon_pop(input string name, input logic [7:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got event %0h with nothing expected", name, got);
    end else begin
      chk(name, {120'd0, got}, {120'd0, exp_q.pop_front()});
    end
  endtask

  always @(negedge clk) begin
    if (round_en) mon_pop("round_event", {3'd1, round_last, round_sel});
    if (blk_done) mon_pop("done_event", {3'd2, 5'd0});
    if (key_err && !err_prev) mon_pop("key_err_event", {3'd3, 5'd0});
    err_prev = key_err;
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_rounds(input int last_seen, input bit with_done);
    for (int i = 0; i <= last_seen; i++)
      exp_q.push_back({3'd1, (i == ROUNDS), 4'(i)});
    if (with_done) exp_q.push_back({3'd2, 5'd0});
  endtask

  task automatic load_key(input logic [127:0] k, input int gen_delay);
    key_valid = 1'b1;
    key_in = k;
    transformer_start = 1'b0;
    #1;
    chk("key_ready_before_load", key_ready, 1);
    tick;
    key_valid = 1'b0;
    chk("key_q_latched", key_q, k);
    chk("key_start_after_load", key_start, 1);
    chk("key_err_clear_on_load", key_err, 0);
    chk("busy_in_keygen", busy, 1);
    for (int i = 0; i < gen_delay; i++) begin
      chk("key_start_held", key_start, 1);
      tick;
    end
    transformer_start = 1'b1;
    tick;
    chk("key_start_dropped", key_start, 0);
    chk("state_ready_after_keygen", state_dbg, ST_READY);
    chk("key_ready_in_ready", key_ready, 1);
    chk("blk_ready_in_ready", blk_ready, 1);
    chk("busy_low_in_ready", busy, 0);
  endtask

  task automatic run_block;
    int n;
    push_rounds(ROUNDS, 1'b1);
    blk_valid = 1'b1;
    #1;
    chk("blk_ready_offer", blk_ready, 1);
    tick;
    blk_valid = 1'b0;
    chk("round_en_first", round_en, 1);
    chk("round_sel_first", round_sel, 0);
    n = 0;
    while (!blk_done && n < 40) begin
      tick;
      n++;
    end
    chk("blk_done_latency", n, ROUNDS + 1);
    chk("blk_ready_in_done", blk_ready, 0);
    chk("key_ready_in_done", key_ready, 0);
    tick;
    chk("blk_done_one_cycle", blk_done, 0);
    chk("blk_ready_after_done", blk_ready, 1);
  endtask

  initial begin
    int n;
    int done_cyc[$];
    rst_ = 1'b1;
    key_valid = 1'b0;
    key_in = '0;
    blk_valid = 1'b0;
    transformer_start = 1'b0;
    #2;
    // reset state
    chk("rst_key_start", key_start, 0);
    chk("rst_round_en", round_en, 0);
    chk("rst_blk_done", blk_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_blk_ready", blk_ready, 0);
    chk("rst_key_q", key_q, 0);
    chk("rst_round_sel", round_sel, 0);
    tick;
    tick;
    rst_ = 1'b0;
    tick;

    // 1: key load with generator responding after 5 cycles
    load_key(128'h2475A2B33475568831E2120013AA5487, 5);

    // 2: single block
    run_block;

    // 3: generator never responds -> timeout after TO cycles in KEYGEN
    key_valid = 1'b1;
    key_in = 128'h0123456789ABCDEF0011223344556677;
    transformer_start = 1'b0;
    exp_q.push_back({3'd3, 5'd0});
    tick;
    key_valid = 1'b0;
    n = 0;
    while (!key_err && n < 100) begin
      if (blk_ready) chk("blk_ready_low_in_keygen", blk_ready, 0);
      tick;
      n++;
    end
    chk("timeout_cycles", n, TO);
    chk("err_state", state_dbg, ST_ERR);
    chk("err_key_start", key_start, 0);
    chk("err_key_ready", key_ready, 1);
    chk("err_blk_ready", blk_ready, 0);
    chk("err_busy", busy, 0);
    load_key(128'hFEDCBA98765432100F1E2D3C4B5A6978, 3);

    // 4: key and block together in READY -> key wins, block taken after rekey
    key_valid = 1'b1;
    blk_valid = 1'b1;
    key_in = 128'h00112233445566778899AABBCCDDEEFF;
    transformer_start = 1'b0;
    #1;
    chk("collide_blk_ready", blk_ready, 0);
    chk("collide_key_ready", key_ready, 1);
    tick;
    key_valid = 1'b0;
    chk("collide_key_q", key_q, 128'h00112233445566778899AABBCCDDEEFF);
    chk("collide_keygen", state_dbg, ST_KEYGEN);
    for (int i = 0; i < 3; i++) begin
      chk("collide_blk_ready_keygen", blk_ready, 0);
      tick;
    end
    transformer_start = 1'b1;
    tick;
    run_block;

    // 5: reset while round_sel is 5
    push_rounds(4, 1'b0);
    blk_valid = 1'b1;
    tick;
    blk_valid = 1'b0;
    n = 0;
    while (round_sel != 4'd5 && n < 20) begin
      tick;
      n++;
    end
    chk("reach_round5", round_sel, 5);
    rst_ = 1'b1;
    #1;
    chk("abort_key_start", key_start, 0);
    chk("abort_round_en", round_en, 0);
    chk("abort_blk_done", blk_done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_round_sel", round_sel, 0);
    chk("abort_key_q", key_q, 0);
    chk("abort_key_ready", key_ready, 1);
    chk("abort_blk_ready", blk_ready, 0);
    tick;
    rst_ = 1'b0;
    blk_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("abort_blk_ready_hold", blk_ready, 0);
      tick;
    end
    blk_valid = 1'b0;
    chk("abort_idle", state_dbg, ST_IDLE);
    load_key(128'h2B7E151628AED2A6ABF7158809CF4F3C, 2);

    // 6: back-to-back blocks with blk_valid held high
    push_rounds(ROUNDS, 1'b1);
    push_rounds(ROUNDS, 1'b1);
    push_rounds(ROUNDS, 1'b1);
    blk_valid = 1'b1;
    n = 0;
    while (done_cyc.size() < 3 && n < 80) begin
      tick;
      n++;
      if (blk_done) begin
        done_cyc.push_back(cyc);
        if (done_cyc.size() == 3) blk_valid = 1'b0;
      end
    end
    chk("b2b_done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      chk("b2b_spacing_1", done_cyc[1] - done_cyc[0], ROUNDS + 3);
      chk("b2b_spacing_2", done_cyc[2] - done_cyc[1], ROUNDS + 3);
    end
    for (int i = 0; i < 5; i++) tick;
    chk("b2b_back_to_ready", state_dbg, ST_READY);
    chk("exp_q_drained", exp_q.size(), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
